seq_control_unit: RTL and testbench

Parametrised multi-cycle control unit for the 8-bit CPU. It accepts one opcode at a time over a valid/ready handshake and drives `alu_sel`. It sequences single-cycle ALU ops (add, sub, and, or, xor, compare) and the iterative ALU ops (product, div) through a decode/execute/writeback FSM, then issues the register-file or flag write strobe. It sits between instruction fetch and the ALU/register file, and replaces the purely combinational opcode decoder.

---
 rtl/seq_control_unit_pkg.sv | 32 +++
 rtl/seq_control_unit_if.sv | 29 ++
 rtl/seq_control_unit_watchdog.sv | 29 ++
 rtl/seq_control_unit.sv | 90 +++++++++
 tb/tb_seq_control_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_control_unit_pkg.sv
// Shared definitions for the sequencing control unit: opcode encodings,
// FSM state type and opcode classification helpers.
package cu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_DIV = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_WAIT,
        ST_WB,
        ST_ERR
    } cu_state_t;

    function automatic logic is_iterative(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Callers zero-extend the opcode, so wide opcode buses are handled uniformly.
    function automatic logic is_legal(input logic [31:0] op);
        return op < 32'd8;
    endfunction

endpackage

// File: rtl/seq_control_unit_if.sv
// Instruction handshake, ALU control and status bundle of the control unit.
// The unit itself uses the slave modport; the fetch/ALU side uses master.
interface seq_control_unit_if #(
    parameter int OPCODE_W  = 3,
    parameter int ALU_SEL_W = 3,
    parameter int CNT_W     = 16
);
    logic                 instr_valid;
    logic                 instr_ready;
    logic [OPCODE_W-1:0]  opcode;
    logic [ALU_SEL_W-1:0] alu_sel;
    logic                 alu_start;
    logic                 alu_done;
    logic                 reg_we;
    logic                 flag_we;
    logic                 err;
    logic                 busy;
    logic [CNT_W-1:0]     retired_cnt;

    modport master (
        output instr_valid, opcode, alu_done,
        input  instr_ready, alu_sel, alu_start, reg_we, flag_we, err, busy, retired_cnt
    );

    modport slave (
        input  instr_valid, opcode, alu_done,
        output instr_ready, alu_sel, alu_start, reg_we, flag_we, err, busy, retired_cnt
    );
endinterface

// File: rtl/seq_control_unit_watchdog.sv
// WAIT-state timeout counter; compiled only when CU_TIMEOUT_EN is defined.
// Counts consecutive WAIT cycles and flags the TIMEOUT_CYCLES-th one.
`ifdef CU_TIMEOUT_EN
module cu_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_i,
    output logic expired_o
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Leaving WAIT clears the count, so every entry starts from zero.
    always_comb begin
        cnt_d = '0;
        if (wait_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired_o = wait_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));
endmodule
`endif

// File: rtl/seq_control_unit.sv
// Multi-cycle opcode sequencer: IDLE/DECODE/EXEC/WAIT/WB/ERR FSM driving the ALU
// select, iterative-op start and write strobes. CU_TIMEOUT_EN adds a WAIT watchdog.
module seq_control_unit
    import cu_pkg::*;
#(
    parameter int OPCODE_W       = 3,
    parameter int ALU_SEL_W      = 3,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    seq_control_unit_if.slave bus
);
    cu_state_t           state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic [2:0]          op3;
    logic                legal;
    logic                timeout;

    assign op3   = opcode_q[2:0];
    assign legal = is_legal(32'(opcode_q));

`ifdef CU_TIMEOUT_EN
    cu_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .wait_i    (state_q == ST_WAIT),
        .expired_o (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    opcode_d = bus.opcode;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!legal)                 state_d = ST_ERR;
                else if (is_iterative(op3)) state_d = ST_WAIT;
                else                        state_d = ST_EXEC;
            end
            ST_EXEC: state_d = ST_WB;
            // A done on the timeout cycle still completes the instruction.
            ST_WAIT: begin
                if (bus.alu_done)  state_d = ST_WB;
                else if (timeout)  state_d = ST_ERR;
            end
            ST_WB: begin
                retired_d = retired_q + 1'b1;
                state_d   = ST_IDLE;
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            retired_q <= retired_d;
        end
    end

    // Outputs are decoded from registered state only; instr_ready also gates on rst.
    assign bus.instr_ready = (state_q == ST_IDLE) && !rst;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.alu_sel     = (state_q == ST_IDLE) ? '0 : ALU_SEL_W'(op3);
    assign bus.alu_start   = (state_q == ST_DECODE) && legal && is_iterative(op3);
    assign bus.reg_we      = (state_q == ST_WB) && (op3 != OP_CMP);
    assign bus.flag_we     = (state_q == ST_WB) && (op3 == OP_CMP);
    assign bus.err         = (state_q == ST_ERR);
    assign bus.retired_cnt = retired_q;
endmodule

// File: tb/tb_seq_control_unit.sv
// Scoreboard bench for seq_control_unit: directed opcodes push expected strobes
// (kind, cycle, alu_sel, count) that a negedge monitor pops and compares.
module tb_seq_control_unit;
    localparam int OPCODE_W = 4;
    localparam int ALU_SEL_W = 3;
    localparam int CNT_W = 4;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int CNT_MASK = (1 << CNT_W) - 1;

    localparam int K_REG  = 1;
    localparam int K_FLAG = 2;
    localparam int K_ERR  = 4;

    typedef struct {
        int kind;
        int sel;
        int cnt;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    exp_t sb_q[$];
    int   start_q[$];

    seq_control_unit_if #(.OPCODE_W(OPCODE_W), .ALU_SEL_W(ALU_SEL_W), .CNT_W(CNT_W)) bus ();

    seq_control_unit #(
        .OPCODE_W(OPCODE_W), .ALU_SEL_W(ALU_SEL_W),
        .CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int sel, input int cnt, input int at);
        exp_t e;
        e.kind = kind; e.sel = sel; e.cnt = cnt & CNT_MASK; e.cyc = at;
        sb_q.push_back(e);
    endtask

    // Monitor: every strobe or alu_start must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.reg_we || bus.flag_we || bus.err) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", {bus.err, bus.flag_we, bus.reg_we}, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("strobe_kind", {bus.err, bus.flag_we, bus.reg_we}, e.kind);
                chk("strobe_cycle", cyc, e.cyc);
                chk("strobe_alu_sel", bus.alu_sel, e.sel);
                chk("strobe_cnt", bus.retired_cnt, e.cnt);
            end
        end
        if (bus.alu_start) begin
            if (start_q.size() == 0) chk("unexpected_alu_start", 1, 0);
            else                     chk("alu_start_cycle", cyc, start_q.pop_front());
        end
    end

    task automatic issue(input logic [OPCODE_W-1:0] op, output int nacc);
        @(negedge clk);
        chk("ready_before_issue", bus.instr_ready, 1);
        bus.instr_valid = 1'b1;
        bus.opcode      = op;
        @(posedge clk);
        #1;
        nacc            = cyc;
        bus.instr_valid = 1'b0;
        bus.opcode      = ~op;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 40);
        chk("back_to_idle", bus.busy, 0);
        chk("scoreboard_drained", sb_q.size() + start_q.size(), 0);
    endtask

    task automatic run_single(input logic [OPCODE_W-1:0] op, input int kind, input int sel);
        int nacc;
        issue(op, nacc);
        push(kind, sel, exp_cnt, nacc + 2);
        exp_cnt++;
        @(negedge clk);
        chk("busy_in_decode", bus.busy, 1);
        wait_idle();
        chk("retired_cnt", bus.retired_cnt, exp_cnt & CNT_MASK);
    endtask

    task automatic run_iter(input logic [OPCODE_W-1:0] op, input int delay);
        int nacc;
        issue(op, nacc);
        start_q.push_back(nacc);
        @(negedge clk);
        chk("busy_in_decode", bus.busy, 1);
        repeat (delay) begin
            @(negedge clk);
            chk("busy_in_wait", bus.busy, 1);
        end
        @(negedge clk);
        chk("busy_in_wait", bus.busy, 1);
        bus.alu_done = 1'b1;
        push(K_REG, int'(op[2:0]), exp_cnt, cyc + 1);
        exp_cnt++;
        @(negedge clk);
        bus.alu_done = 1'b0;
        wait_idle();
        chk("retired_cnt", bus.retired_cnt, exp_cnt & CNT_MASK);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nacc;
        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
        bus.alu_done    = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_instr_ready", bus.instr_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_alu_sel", bus.alu_sel, 0);
        chk("rst_strobes", {bus.alu_start, bus.reg_we, bus.flag_we, bus.err}, 0);
        chk("rst_retired", bus.retired_cnt, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", bus.instr_ready, 1);

        // add: reg_we at N+3 (cycle nacc+2), alu_sel 0, count 1
        run_single(4'd0, K_REG, 0);

        // compare: flag_we only, alu_sel 7 in DECODE and EXEC
        issue(4'd7, nacc);
        push(K_FLAG, 7, exp_cnt, nacc + 2);
        exp_cnt++;
        @(negedge clk);
        chk("cmp_sel_decode", bus.alu_sel, 7);
        @(negedge clk);
        chk("cmp_sel_exec", bus.alu_sel, 7);
        wait_idle();
        chk("retired_cnt", bus.retired_cnt, exp_cnt);

        // div with done after 5 WAIT cycles; mul with minimum latency
        run_iter(4'd6, 5);
        run_iter(4'd5, 0);

        // remaining single-cycle ops
        run_single(4'd1, K_REG, 1);
        run_single(4'd2, K_REG, 2);
        run_single(4'd3, K_REG, 3);
        run_single(4'd4, K_REG, 4);

        // stray alu_done while idle
        @(negedge clk);
        bus.alu_done = 1'b1;
        @(negedge clk);
        bus.alu_done = 1'b0;
        chk("stray_done_busy", bus.busy, 0);
        @(negedge clk);
        chk("stray_done_cnt", bus.retired_cnt, exp_cnt);

        // illegal opcode 9: err at N+2, ready again at N+3, no count
        issue(4'd9, nacc);
        push(K_ERR, 1, exp_cnt, nacc + 1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("illegal_ready_again", bus.instr_ready, 1);
        chk("illegal_cnt", bus.retired_cnt, exp_cnt);

`ifdef CU_TIMEOUT_EN
        // mul with no done: ERR after 8 WAIT cycles
        issue(4'd5, nacc);
        start_q.push_back(nacc);
        push(K_ERR, 5, exp_cnt, nacc + 9);
        wait_idle();
        chk("timeout_cnt", bus.retired_cnt, exp_cnt);

        // done on the limit cycle wins
        issue(4'd5, nacc);
        start_q.push_back(nacc);
        repeat (9) @(negedge clk);
        bus.alu_done = 1'b1;
        push(K_REG, 5, exp_cnt, nacc + 9);
        exp_cnt++;
        @(negedge clk);
        bus.alu_done = 1'b0;
        wait_idle();
        chk("limit_done_cnt", bus.retired_cnt, exp_cnt);
`endif

        // reset while in WAIT drops the instruction
        issue(4'd6, nacc);
        start_q.push_back(nacc);
        @(negedge clk);
        @(negedge clk);
        chk("wait_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_alu_sel", bus.alu_sel, 0);
        chk("midrst_strobes", {bus.alu_start, bus.reg_we, bus.flag_we, bus.err}, 0);
        chk("midrst_ready", bus.instr_ready, 0);
        chk("midrst_cnt", bus.retired_cnt, 0);
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        chk("post_rst_ready", bus.instr_ready, 1);

        // 16 instructions wrap the 4-bit counter back to 0
        for (int i = 0; i < 16; i++) begin
            logic [OPCODE_W-1:0] op;
            op = OPCODE_W'(i % 8);
            if (op == 4'd5 || op == 4'd6) run_iter(op, 0);
            else if (op == 4'd7)          run_single(op, K_FLAG, 7);
            else                          run_single(op, K_REG, i % 8);
        end
        chk("wrap_cnt", bus.retired_cnt, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
